// File: rtl/audionet_pkg.sv
// Shared types and constants for the SPI-to-register-bus bridge.
// Frame geometry, bus widths and bridge FSM states.
package audionet_pkg;

  localparam int FRAME_BITS = 48;
  localparam int HDR_BITS   = 16;
  localparam int REG_ADDR_W = 10;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_DATA_W-1:0] TMO_FILL = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_DATA,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DRAIN
  } st_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with registered-history edge pulses.
// primed rises once the chain holds only real samples.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic primed
);

  logic [STAGES-1:0] ff;
  logic              prev;
  logic [STAGES:0]   fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff   <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
      fill <= '0;
    end else begin
      ff   <= {ff[STAGES-2:0], d};
      prev <= ff[STAGES-1];
      fill <= {fill[STAGES-1:0], 1'b1};
    end
  end

  assign q      = ff[STAGES-1];
  assign rise   = q & ~prev;
  assign fall   = ~q & prev;
  assign primed = fill[STAGES];

endmodule

// File: rtl/spi_regs_bridge.sv
// SPI mode-0 slave that issues one register-bus transaction per frame.
// All SPI pins are oversampled in the clk domain.
module spi_regs_bridge
  import audionet_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_csn,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic                  val,
  output logic [REG_ADDR_W-1:0] addr,
  output logic                  write,
  output logic [REG_DATA_W-1:0] wdata,
  input  logic [REG_DATA_W-1:0] rdata,
  input  logic                  ready,
  output logic                  busy,
  output logic                  err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic sclk_q, sclk_rise, sclk_fall, sclk_primed;
  logic csn_q, csn_rise, csn_fall, csn_primed;
  logic mosi_q, mosi_rise, mosi_fall, mosi_primed;

  st_e                   state, state_n;
  logic [5:0]            bitcnt;
  logic [REG_DATA_W-1:0] sh_in, sh_out;
  logic                  miso_q, wr_q, armed;
  logic [TW-1:0]         tcnt;
  logic                  last_hdr, last_frm, tmo;
  logic [HDR_BITS-1:0]   hdr;
  logic                  unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(spi_sclk), .q(sclk_q),
    .rise(sclk_rise), .fall(sclk_fall), .primed(sclk_primed)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn (
    .clk(clk), .rst(rst), .d(spi_csn), .q(csn_q),
    .rise(csn_rise), .fall(csn_fall), .primed(csn_primed)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_q),
    .rise(mosi_rise), .fall(mosi_fall), .primed(mosi_primed)
  );

  assign unused = ^{sclk_q, sclk_primed, csn_rise, mosi_rise,
                    mosi_fall, mosi_primed, sh_in[31], hdr[14:10]};

  assign hdr      = {sh_in[HDR_BITS-2:0], mosi_q};
  assign last_hdr = sclk_rise && bitcnt == 6'(HDR_BITS - 1);
  assign last_frm = sclk_rise && bitcnt == 6'(FRAME_BITS - 1);
  assign tmo      = tcnt == TW'(TIMEOUT - 1);

  assign val         = state == ST_RD_REQ || state == ST_WR_REQ;
  assign write       = wr_q;
  assign busy        = state != ST_IDLE;
  assign spi_miso_oe = ~csn_q;
  assign spi_miso    = miso_q & (state == ST_DATA) & ~wr_q;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:    if (armed && csn_fall) state_n = ST_HDR;
      ST_HDR: begin
        if (csn_q)         state_n = ST_IDLE;
        else if (last_hdr) state_n = hdr[15] ? ST_DATA : ST_RD_REQ;
      end
      ST_RD_REQ:  state_n = ST_RD_WAIT;
      ST_RD_WAIT: if (ready || tmo) state_n = ST_DATA;
      ST_DATA: begin
        if (csn_q)         state_n = ST_IDLE;
        else if (last_frm) state_n = wr_q ? ST_WR_REQ : ST_DRAIN;
      end
      ST_WR_REQ:  state_n = ST_WR_WAIT;
      ST_WR_WAIT: if (ready || tmo) state_n = ST_DRAIN;
      ST_DRAIN:   if (csn_q) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      bitcnt <= '0;
      sh_in  <= '0;
      sh_out <= '0;
      miso_q <= 1'b0;
      wr_q   <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      err    <= 1'b0;
      tcnt   <= '0;
      armed  <= 1'b0;
    end else begin
      state <= state_n;
      armed <= armed | (csn_primed & csn_q);
      tcnt  <= (state == ST_RD_WAIT || state == ST_WR_WAIT) ?
               tcnt + 1'b1 : '0;
      unique case (state)
        ST_IDLE: begin
          if (armed && csn_fall) begin
            bitcnt <= '0;
            sh_in  <= '0;
            sh_out <= '0;
            miso_q <= 1'b0;
          end
        end
        ST_HDR: begin
          if (sclk_rise) begin
            sh_in  <= {sh_in[30:0], mosi_q};
            bitcnt <= bitcnt + 6'd1;
          end
          if (last_hdr) begin
            wr_q <= hdr[15];
            addr <= hdr[REG_ADDR_W-1:0];
          end
        end
        ST_RD_WAIT: begin
          if (ready) begin
            sh_out <= rdata;
          end else if (tmo) begin
            sh_out <= TMO_FILL;
            err    <= 1'b1;
          end
        end
        ST_DATA: begin
          if (sclk_rise) begin
            sh_in  <= {sh_in[30:0], mosi_q};
            bitcnt <= bitcnt + 6'd1;
          end
          if (last_frm && wr_q) wdata <= {sh_in[30:0], mosi_q};
          // read data leaves on falling edges, MSB first
          if (sclk_fall && !wr_q) begin
            miso_q <= sh_out[31];
            sh_out <= {sh_out[30:0], 1'b0};
          end
        end
        ST_WR_WAIT: if (!ready && tmo) err <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
